// File: rtl/adc_emul_mc.sv
// Multi-channel ADC emulator: per-channel triangle/sawtooth accumulators packed
// into a double-rate word with a half-rate frame clock and a frame-valid strobe.
module adc_emul_mc #(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 2,
    parameter int LO_LIMIT  = 1,
    parameter int HI_LIMIT  = 14,
    parameter int CH_OFFSET = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [WIDTH-1:0]              step,
    output logic [CHANNELS*2*WIDTH-1:0]   dout,
    output logic                          clk_out,
    output logic                          frame_valid
);

    typedef enum logic [1:0] {
        MODE_TRI   = 2'd0,
        MODE_SAW   = 2'd1,
        MODE_HOLD  = 2'd2,
        MODE_TRAIN = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [WIDTH:0]   LO_EXT = (WIDTH+1)'(LO_LIMIT);
    localparam logic [WIDTH:0]   HI_EXT = (WIDTH+1)'(HI_LIMIT);
    localparam logic [WIDTH-1:0] LO_VAL = WIDTH'(LO_LIMIT);
    localparam logic [WIDTH-1:0] HI_VAL = WIDTH'(HI_LIMIT);
    // Training words: odd bits set on the p half, even bits set on the n half.
    localparam logic [WIDTH-1:0] PAT_P  = WIDTH'({(WIDTH+1)/2{2'b10}});
    localparam logic [WIDTH-1:0] PAT_N  = ~PAT_P;

    mode_e mode_sel;

    logic [WIDTH-1:0]            acc_q    [CHANNELS];
    logic [WIDTH-1:0]            acc_d    [CHANNELS];
    dir_e                        dir_q    [CHANNELS];
    dir_e                        dir_d    [CHANNELS];
    logic [WIDTH:0]              sum_up   [CHANNELS];
    logic [WIDTH:0]              dn_floor [CHANNELS];
    logic [WIDTH-1:0]            cap_val  [CHANNELS];

    logic                        phase_q;
    logic                        phase_d;
    logic [CHANNELS*2*WIDTH-1:0] dout_q;
    logic [CHANNELS*2*WIDTH-1:0] dout_d;
    logic                        fv_q;
    logic                        fv_d;

    assign mode_sel = mode_e'(mode);

    // Accumulator update: all arithmetic one bit wider so limits clamp instead of wrapping.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            acc_d[c]    = acc_q[c];
            dir_d[c]    = dir_q[c];
            sum_up[c]   = {1'b0, acc_q[c]} + {1'b0, step};
            dn_floor[c] = LO_EXT + {1'b0, step};

            if (en && (step != '0)) begin
                case (mode_sel)
                    MODE_TRI: begin
                        if (dir_q[c] == DIR_UP) begin
                            if (sum_up[c] >= HI_EXT) begin
                                acc_d[c] = HI_VAL;
                                dir_d[c] = DIR_DOWN;
                            end else begin
                                acc_d[c] = sum_up[c][WIDTH-1:0];
                            end
                        end else begin
                            if ({1'b0, acc_q[c]} <= dn_floor[c]) begin
                                acc_d[c] = LO_VAL;
                                dir_d[c] = DIR_UP;
                            end else begin
                                acc_d[c] = acc_q[c] - step;
                            end
                        end
                    end
                    MODE_SAW: begin
                        dir_d[c] = DIR_UP;
                        if (sum_up[c] > HI_EXT) begin
                            acc_d[c] = LO_VAL;
                        end else begin
                            acc_d[c] = sum_up[c][WIDTH-1:0];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Capture uses the pre-update accumulator; phase picks the half being written.
    always_comb begin
        dout_d  = dout_q;
        phase_d = phase_q;
        fv_d    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (mode_sel == MODE_TRAIN) begin
                cap_val[c] = phase_q ? PAT_N : PAT_P;
            end else begin
                cap_val[c] = acc_q[c];
            end
        end
        if (en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!phase_q) begin
                    dout_d[c*2*WIDTH +: WIDTH] = cap_val[c];
                end else begin
                    dout_d[c*2*WIDTH+WIDTH +: WIDTH] = cap_val[c];
                end
            end
            phase_d = ~phase_q;
            fv_d    = phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= WIDTH'(LO_LIMIT + c * CH_OFFSET);
                dir_q[c] <= DIR_UP;
            end
            phase_q <= 1'b0;
            dout_q  <= '0;
            fv_q    <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= acc_d[c];
                dir_q[c] <= dir_d[c];
            end
            phase_q <= phase_d;
            dout_q  <= dout_d;
            fv_q    <= fv_d;
        end
    end

    assign dout        = dout_q;
    assign clk_out     = phase_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_adc_emul_mc.sv
// Bench for adc_emul_mc: a fixed vector table, directed multi-cycle sequences,
// then randomized stimulus against a sample-level reference model.
module tb_adc_emul_mc;

    localparam int WIDTH = 4;
    localparam int CHANNELS = 2;
    localparam int LO = 1;
    localparam int HI = 14;
    localparam int OFFS = 4;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  step;
    logic [15:0] dout;
    logic        clk_out;
    logic        frame_valid;

    int errors;
    int checks;

    // Reference model: per-channel waveform value and direction, frame halves.
    int m_acc [CHANNELS];
    int m_down [CHANNELS];
    int m_p [CHANNELS];
    int m_n [CHANNELS];
    int m_phase;
    int m_fv;

    typedef struct {
        logic        reset;
        logic        en;
        logic [1:0]  mode;
        logic [3:0]  step;
        logic [15:0] exp_dout;
        logic        exp_clk;
        logic        exp_fv;
    } vec_t;

    vec_t vecs [20];

    adc_emul_mc #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .LO_LIMIT(LO), .HI_LIMIT(HI), .CH_OFFSET(OFFS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .mode(mode),
        .step(step),
        .dout(dout),
        .clk_out(clk_out),
        .frame_valid(frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelStep();
        int s;
        s = int'(step);
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                m_acc[c] = LO + c * OFFS;
                m_down[c] = 0;
                m_p[c] = 0;
                m_n[c] = 0;
            end
            m_phase = 0;
            m_fv = 0;
        end else if (en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                int v;
                if (mode == 2'd3) v = (m_phase == 0) ? 'hA : 'h5;
                else v = m_acc[c];
                if (m_phase == 0) m_p[c] = v;
                else m_n[c] = v;
            end
            m_fv = m_phase;
            m_phase = 1 - m_phase;
            for (int c = 0; c < CHANNELS; c++) begin
                if (s != 0) begin
                    if (mode == 2'd0) begin
                        if (m_down[c] == 0) begin
                            if (m_acc[c] + s >= HI) begin m_acc[c] = HI; m_down[c] = 1; end
                            else m_acc[c] = m_acc[c] + s;
                        end else begin
                            if (m_acc[c] <= LO + s) begin m_acc[c] = LO; m_down[c] = 0; end
                            else m_acc[c] = m_acc[c] - s;
                        end
                    end else if (mode == 2'd1) begin
                        m_down[c] = 0;
                        m_acc[c] = (m_acc[c] + s > HI) ? LO : m_acc[c] + s;
                    end
                end
                if (m_acc[c] < LO || m_acc[c] > HI) begin
                    $display("[TB] model value out of range ch%0d = %0d", c, m_acc[c]);
                end
            end
        end else begin
            m_fv = 0;
        end
    endtask

    function automatic logic [15:0] modelDout();
        logic [15:0] e;
        int pv;
        int nv;
        e = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pv = m_p[c];
            nv = m_n[c];
            e[c*8 +: 4] = pv[3:0];
            e[c*8+4 +: 4] = nv[3:0];
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m, input logic [3:0] s);
        reset = r;
        en = e;
        mode = m;
        step = s;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] exp_dout,
                               input logic exp_clk, input logic exp_fv);
        checks++;
        if (dout !== exp_dout) begin
            errors++;
            $display("[TB] FAIL %s dout: got %h expected %h", name, dout, exp_dout);
        end
        checks++;
        if (clk_out !== exp_clk) begin
            errors++;
            $display("[TB] FAIL %s clk_out: got %b expected %b", name, clk_out, exp_clk);
        end
        checks++;
        if (frame_valid !== exp_fv) begin
            errors++;
            $display("[TB] FAIL %s frame_valid: got %b expected %b", name, frame_valid, exp_fv);
        end
    endtask

    // Runs a fresh sequence from reset and checks the half captured by each edge for both channels.
    task automatic captureSequence(input string name, input logic [1:0] m, input int n_edges,
                                   input int steps [8], input int exp0 [8], input int exp1 [8]);
        logic [3:0] got;
        applyStimulus(1'b1, 1'b0, m, 4'd0);
        tick();
        for (int k = 0; k < n_edges; k++) begin
            applyStimulus(1'b0, 1'b1, m, 4'(steps[k]));
            tick();
            for (int c = 0; c < CHANNELS; c++) begin
                got = (k % 2 == 0) ? dout[c*8 +: 4] : dout[c*8+4 +: 4];
                checks++;
                if (int'(got) != ((c == 0) ? exp0[k] : exp1[k])) begin
                    errors++;
                    $display("[TB] FAIL %s edge%0d ch%0d: got %0d expected %0d",
                             name, k, c, got, (c == 0) ? exp0[k] : exp1[k]);
                end
            end
        end
    endtask

    initial begin
        int s_saw [8];
        int e_saw0 [8];
        int e_saw1 [8];
        int s_t15 [8];
        int e_t150 [8];
        int e_t151 [8];
        int s_z [8];
        int e_z0 [8];
        int e_z1 [8];
        logic [1:0] rm;

        errors = 0;
        checks = 0;
        applyStimulus(1'b1, 1'b0, 2'd0, 4'd1);

        vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'd1,  16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'd0, 4'd1,  16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 2'd0, 4'd1,  16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, 4'd1,  16'h0501, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, 4'd1,  16'h6521, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'd1,  16'h6723, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 4'd1,  16'h6723, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 4'd1,  16'h6723, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'd1,  16'h8743, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 2'd3, 4'd1,  16'h8A4A, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 4'd1,  16'h5A5A, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 2'd2, 4'd1,  16'h5955, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'd2, 4'd1,  16'h9955, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 2'd1, 4'd5,  16'h9955, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'd1, 4'd5,  16'hE9A5, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 2'd1, 4'd5,  16'hE1A1, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 2'd1, 4'd5,  16'h0000, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 2'd0, 4'd15, 16'h0501, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 2'd0, 4'd15, 16'hE5E1, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 2'd0, 4'd15, 16'hE5E1, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].reset, vecs[i].en, vecs[i].mode, vecs[i].step);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_clk, vecs[i].exp_fv);
        end

        s_saw  = '{5, 5, 5, 5, 5, 5, 5, 5};
        e_saw0 = '{1, 6, 11, 1, 6, 11, 1, 6};
        e_saw1 = '{5, 10, 1, 6, 11, 1, 6, 11};
        captureSequence("saw_step5", 2'd1, 8, s_saw, e_saw0, e_saw1);

        s_t15  = '{15, 15, 15, 15, 15, 15, 15, 15};
        e_t150 = '{1, 14, 1, 14, 1, 14, 1, 14};
        e_t151 = '{5, 14, 1, 14, 1, 14, 1, 14};
        captureSequence("tri_step15", 2'd0, 8, s_t15, e_t150, e_t151);

        // One big step lands ch0 at the top going down; step 0 must then freeze value and direction.
        s_z  = '{15, 0, 0, 0, 1, 1, 1, 1};
        e_z0 = '{1, 14, 14, 14, 14, 13, 12, 11};
        e_z1 = '{5, 14, 14, 14, 14, 13, 12, 11};
        captureSequence("tri_step0", 2'd0, 8, s_z, e_z0, e_z1);

        // Full triangle period on ch0, then en low mid-frame, then reset while descending.
        applyStimulus(1'b1, 1'b0, 2'd0, 4'd1);
        tick();
        for (int k = 0; k < 41; k++) begin
            applyStimulus(1'b0, 1'b1, 2'd0, 4'd1);
            tick();
            checkOutput($sformatf("tri_period%0d", k), modelDout(), m_phase[0], m_fv[0]);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 4'd1);
            tick();
            checkOutput($sformatf("freeze%0d", k), modelDout(), 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 2'd0, 4'd1);
        tick();
        checkOutput("reset_mid", 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'd1);
        tick();
        checkOutput("after_reset_p", 16'h0501, 1'b1, 1'b0);
        tick();
        checkOutput("after_reset_n", 16'h6521, 1'b0, 1'b1);

        for (int k = 0; k < 600; k++) begin
            rm = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rm,
                          4'((rm == 2'd1) ? $urandom_range(1, 15) : $urandom_range(0, 15)));
            tick();
            checkOutput($sformatf("rand%0d", k), modelDout(), m_phase[0], m_fv[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_emul_mc.md
Name: adc_emul_mc

Overview:
Multi-channel, parametrised ADC emulator that replaces the single-channel triangle source for bench and board bring-up. Each channel has its own waveform accumulator with a programmable step, bounds and mode (triangle, sawtooth, hold, training pattern). Samples are packed into a double-rate word (p half on even phase, n half on odd phase) with a half-rate frame clock and a frame-valid strobe. Everything runs in one clock domain; there is no logic clocked by derived signals.

Parameters:
WIDTH, 4, bits per sample half (per-lane width)
CHANNELS, 2, number of independent emulated channels
LO_LIMIT, 1, lower bound of the accumulator (unsigned, < HI_LIMIT)
HI_LIMIT, 14, upper bound of the accumulator (unsigned, <= 2^WIDTH-1)
CH_OFFSET, 4, reset-value spacing between channels; LO_LIMIT+(CHANNELS-1)*CH_OFFSET <= HI_LIMIT

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  advance enable; low = freeze all state
mode  in  2  0 triangle, 1 sawtooth, 2 hold, 3 training pattern
step  in  WIDTH  accumulator increment per enabled cycle
dout  out  CHANNELS*2*WIDTH  channel c at [c*2*WIDTH +: 2*WIDTH]; p half low WIDTH bits, n half high WIDTH bits
clk_out  out  1  frame clock = phase register
frame_valid  out  1  one-cycle pulse, both halves of dout updated

Behaviour:
- Reset (priority over en): acc_c = LO_LIMIT + c*CH_OFFSET; dir_c = up; phase = 0; dout = 0; clk_out = 0; frame_valid = 0.
- en=0: acc, dir, phase, dout held; frame_valid = 0.
- Accumulator arithmetic is WIDTH+1 bits wide; no wrap-around through 0 or 2^WIDTH.
- Triangle: up: if acc+step >= HI_LIMIT then acc=HI_LIMIT, dir=down, else acc+=step. Down: if acc <= LO_LIMIT+step then acc=LO_LIMIT, dir=up, else acc-=step.
- Sawtooth: if acc+step > HI_LIMIT then acc=LO_LIMIT, else acc+=step; dir forced up.
- Hold: acc and dir unchanged.
- step=0: acc unchanged in all modes; dir does not flip.
- step >= HI_LIMIT-LO_LIMIT in triangle: acc alternates between the two limits on each cycle.
- Mode change takes effect on the next enabled edge; dir is retained except that sawtooth forces it up.
- Capture per enabled edge, using the acc value before that edge's update:
  - phase=0: p half of every channel <= acc_c (mode 3: 1010... pattern); phase -> 1.
  - phase=1: n half <= acc_c (mode 3: 0101... pattern); phase -> 0; frame_valid = 1 in the following cycle.
- Latency: a sample appears on dout 1 cycle after the edge on which it was the current acc. frame_valid period = 2 enabled cycles.
- Reset mid-operation: all state returns to reset values on the next edge; the first frame after reset starts at phase 0.

Test Plan:
Defaults, step=1, mode=0, assert reset 3 cycles -> dout=0x0000, clk_out=0, frame_valid=0; first p capture is ch0=1, ch1=5.
Triangle, step=1, en=1 -> ch0 acc sequence 1,2..14,13..1,2 (period 26); after 2 cycles dout[7:0]=0x21 and dout[15:8]=0x65; frame_valid high every 2nd cycle; clk_out toggles each cycle.
Sawtooth, step=5 -> ch0 sequence 1,6,11,1,6; ch1 sequence 5,10,1,6; no value ever exceeds 14.
Mode 3 for 2 cycles -> dout=0x5A5A, frame_valid pulse; then switch to hold -> dout reflects frozen acc values.
Triangle, step=15 -> ch0 alternates 1,14,1,14; step=0 -> acc constant and dir unchanged.
en low for 5 cycles mid-frame (phase=1) -> dout, clk_out and acc frozen, frame_valid=0; then reset while dir=down -> next cycle acc=1/5, dir up, phase 0.
